// File: rtl/anim_step_timer.sv
// Animation step pacer: counts VGA frames (vsync falling edges) and issues a one-cycle
// step_pulse every FRAMES_PER_STEP frames, with a wrapping phase index and one-shot mode.
module anim_step_timer #(
    parameter int unsigned FRAMES_PER_STEP = 15,
    parameter int unsigned PHASE_W         = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               vsync,
    input  logic               run,
    input  logic               pause,
    input  logic               one_shot,
    input  logic [7:0]         num_steps,
    output logic               step_pulse,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic [7:0]       steps_left;
    logic             one_shot_r;

    logic vs_meta, vs_sync, vs_prev;
    logic frame_tick;

    // Sync chain resets high so a low vsync at reset release is not mistaken for a fall.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            vs_meta <= vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign frame_tick = vs_prev & ~vs_sync;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            frame_cnt  <= '0;
            steps_left <= '0;
            one_shot_r <= 1'b0;
            phase      <= '0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    frame_cnt <= '0;
                    phase     <= '0;
                    if (run) begin
                        one_shot_r <= one_shot;
                        steps_left <= num_steps;
                        if (one_shot && (num_steps == 8'd0)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (!run) begin
                        state      <= S_IDLE;
                        frame_cnt  <= '0;
                        steps_left <= '0;
                        phase      <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                    end else if (pause) begin
                        state <= S_PAUSE;
                    end else if (frame_tick) begin
                        if (frame_cnt == LAST_FRAME) begin
                            frame_cnt  <= '0;
                            step_pulse <= 1'b1;
                            phase      <= phase + 1'b1;
                            if (one_shot_r) begin
                                if (steps_left != 8'd0)
                                    steps_left <= steps_left - 8'd1;
                                // Final step still pulses; the state change lands with it.
                                if (steps_left == 8'd1) begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                S_PAUSE: begin
                    if (!run) begin
                        state      <= S_IDLE;
                        frame_cnt  <= '0;
                        steps_left <= '0;
                        phase      <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                    end else if (!pause) begin
                        state <= S_RUN;
                    end
                end

                S_DONE: begin
                    if (!run) begin
                        state      <= S_IDLE;
                        frame_cnt  <= '0;
                        steps_left <= '0;
                        phase      <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anim_step_timer.sv
// Directed bench for anim_step_timer with FRAMES_PER_STEP=3, PHASE_W=2.
module tb_anim_step_timer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       vsync = 1'b1;
    logic       run = 1'b0;
    logic       pause = 1'b0;
    logic       one_shot = 1'b0;
    logic [7:0] num_steps = 8'd0;
    logic       step_pulse;
    logic [1:0] phase;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    anim_step_timer #(
        .FRAMES_PER_STEP(3),
        .PHASE_W        (2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .vsync     (vsync),
        .run       (run),
        .pause     (pause),
        .one_shot  (one_shot),
        .num_steps (num_steps),
        .step_pulse(step_pulse),
        .phase     (phase),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; run = 1'b0; pause = 1'b0; vsync = 1'b1; one_shot = 1'b0; num_steps = 8'd0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_pulse", {31'd0, step_pulse}, 0);
        check("rst_phase", {30'd0, phase}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_done",  {31'd0, done}, 0);
        Reset = 1'b0;
    endtask

    // One vsync fall, watched over 8 negedges; a qualifying step shows up in bit 3.
    task automatic frame(input logic pause_on_tick, output logic [7:0] pv);
        @(posedge Clk);
        #1;
        vsync = 1'b0;
        pv = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            pv[i] = step_pulse;
            if (i == 1) vsync = 1'b1;
            if (i == 2 && pause_on_tick) pause = 1'b1;
        end
    endtask

    logic [7:0] pv;
    logic [1:0] exp_phase [15] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                   2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
    int pulses;
    int ticks;

    initial begin
        // Free run: pulses after frames 3,6,9,12,15; phase 1,2,3,0,1
        do_reset();
        one_shot = 1'b0; run = 1'b1;
        @(posedge Clk);
        #1;
        check("t1_busy", {31'd0, busy}, 1);
        check("t1_done", {31'd0, done}, 0);
        for (int f = 1; f <= 15; f++) begin
            frame(1'b0, pv);
            check($sformatf("t1_pv_f%0d", f), {24'd0, pv}, (f % 3 == 0) ? 32'h08 : 32'h00);
            check($sformatf("t1_ph_f%0d", f), {30'd0, phase}, {30'd0, exp_phase[f-1]});
        end
        check("t1_busy_end", {31'd0, busy}, 1);

        // One-shot, 2 steps over 10 frames
        do_reset();
        one_shot = 1'b1; num_steps = 8'd2; run = 1'b1;
        pulses = 0;
        for (int f = 1; f <= 10; f++) begin
            frame(1'b0, pv);
            for (int b = 0; b < 8; b++) pulses += int'(pv[b]);
            if (f == 6) check("t3_done_f6", {31'd0, done}, 1);
        end
        check("t3_pulses", pulses, 2);
        check("t3_phase", {30'd0, phase}, 2);
        check("t3_busy", {31'd0, busy}, 0);
        check("t3_done", {31'd0, done}, 1);
        run = 1'b0;
        @(posedge Clk);
        #1;
        check("t3_idle_phase", {30'd0, phase}, 0);
        check("t3_idle_done", {31'd0, done}, 0);

        // Pause coincident with the tick that would make frame_cnt 2
        do_reset();
        one_shot = 1'b0; run = 1'b1;
        frame(1'b0, pv);
        check("t4_pv1", {24'd0, pv}, 0);
        frame(1'b1, pv);
        check("t4_pv2", {24'd0, pv}, 0);
        check("t4_busy_paused", {31'd0, busy}, 1);
        pulses = 0;
        for (int f = 0; f < 4; f++) begin
            frame(1'b0, pv);
            for (int b = 0; b < 8; b++) pulses += int'(pv[b]);
        end
        check("t4_paused_pulses", pulses, 0);
        @(posedge Clk);
        #1;
        pause = 1'b0;
        frame(1'b0, pv);
        check("t4_resume1", {24'd0, pv}, 0);
        frame(1'b0, pv);
        check("t4_resume2", {24'd0, pv}, 32'h08);
        check("t4_phase", {30'd0, phase}, 1);

        // One-shot with zero steps, long vsync low, then reset mid-run
        do_reset();
        one_shot = 1'b1; num_steps = 8'd0; run = 1'b1;
        @(posedge Clk);
        #1;
        check("t5_done", {31'd0, done}, 1);
        check("t5_busy", {31'd0, busy}, 0);
        vsync = 1'b0;
        pulses = 0;
        ticks = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            pulses += int'(step_pulse);
            ticks  += int'(dut.frame_tick);
        end
        vsync = 1'b1;
        check("t5_ticks", ticks, 1);
        check("t5_pulses", pulses, 0);
        check("t5_phase", {30'd0, phase}, 0);
        run = 1'b0;
        @(posedge Clk);
        #1;
        one_shot = 1'b0; run = 1'b1;
        for (int f = 0; f < 3; f++) frame(1'b0, pv);
        check("t5_pre_rst_phase", {30'd0, phase}, 1);
        check("t5_pre_rst_busy", {31'd0, busy}, 1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("t5_mid_rst_phase", {30'd0, phase}, 0);
        check("t5_mid_rst_busy", {31'd0, busy}, 0);
        check("t5_mid_rst_done", {31'd0, done}, 0);
        check("t5_mid_rst_pulse", {31'd0, step_pulse}, 0);
        Reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
